mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage of the five-stage MIPS core. It registers the execute-stage bus, takes the synchronous data-SRAM read data one cycle after the execute stage issued the address, and aligns and extends it for LW/LB/LBU/LH/LHU/LWL/LWR. It holds that read data across write-back back-pressure, produces per-byte register-file write enables for the partial-word loads, and drives the memory-stage forward/block bus back to decode.

## Interface
- No parameters. Bus widths come from `mycpu.h`: `ES_TO_MS_BUS_WD`=77, `MS_TO_WS_BUS_WD`=73, `MS_FWD_BLK_BUS_WD`=39.
- clk  in  1  core clock; one clock domain.
- reset  in  1  synchronous, active-high.
- ws_allowin  in  1  write-back stage can accept this cycle.
- ms_allowin  out  1  this stage can accept this cycle.
- es_to_ms_valid  in  1  execute-stage instruction valid.
- es_to_ms_bus  in  77  input bus, fields by bit position:
  - [76] lb, [75] lbu, [74] lh, [73] lhu, [72] lwl, [71] lwr.
  - [70] res_from_mem, [69] gr_we, [68:64] dest.
  - [63:32] exe_result (the byte address for loads), [31:0] pc.
- data_sram_rdata  in  32  synchronous SRAM read data.
- ms_to_ws_valid  out  1  output instruction valid.
- ms_to_ws_bus  out  73  output bus: {rf_wen[3:0], dest[4:0], final_result[31:0], pc[31:0]}.
- ms_fwd_blk_bus  out  39  forward/block bus: {fwd_valid[38], rf_dest[37:33], rf_data[32:1], blk_valid[0]}.

## Operation
- Pipeline register:
  - ms_valid loads es_to_ms_valid whenever ms_allowin=1.
  - The bus register loads only when es_to_ms_valid && ms_allowin.
  - ms_ready_go=1; ms_allowin = !ms_valid || ws_allowin; ms_to_ws_valid = ms_valid.
- Read-data hold buffer (rbuf, rbuf_vld):
  - Define "first cycle" as the first cycle ms_valid=1 for a given instruction.
  - In the first cycle of a load with ws_allowin=0, rbuf <= data_sram_rdata and rbuf_vld <= 1.
  - rbuf_vld clears when the instruction leaves (ms_valid && ws_allowin) or on reset.
  - mem_data = rbuf_vld ? rbuf : data_sram_rdata.
- Alignment, with a = exe_result[1:0] and byte k = mem_data[8k+7:8k]:
  - lb/lbu: byte a, sign-extended or zero-extended.
  - lh/lhu: half a[1], sign-extended or zero-extended; a[0] is ignored (no exceptions).
  - lwl: result = mem_data << 8*(3-a); rf_wen = bytes 3 down to 3-a (a=0→4'b1000, a=3→4'b1111).
  - lwr: result = mem_data >> 8*a; rf_wen = bytes 3-a down to 0 (a=0→4'b1111, a=3→4'b0001).
  - res_from_mem with no sub-flag set: word load, result = mem_data.
  - Otherwise: result = exe_result.
- Write enables:
  - rf_wen = 4'h0 when gr_we=0.
  - Otherwise rf_wen = 4'hf, except the lwl/lwr masks above.
- Forward/block: rf_dest = dest; rf_data = final_result; see Configuration for valid gating.

## Timing
- Reset values:
  - ms_valid=0, rbuf_vld=0, rbuf=0.
  - Hence ms_allowin=1, ms_to_ws_valid=0, fwd_valid=0, blk_valid=0.
  - ms_to_ws_bus is don't-care while ms_to_ws_valid=0.
- Latency:
  - An instruction accepted from execute at edge t is valid in this stage during cycle t+1.
  - data_sram_rdata is valid only in cycle t+1; afterwards the SRAM returns data for whatever address execute issues next.
- Stall: if ws_allowin=0 in cycle t+1, the result in every later cycle comes from rbuf and is bit-identical to the cycle t+1 result.
- Back-to-back loads with no stall: each load uses the live SRAM data in its own first cycle, and rbuf is never written.
- Simultaneous leave and accept: with ws_allowin=1, the old instruction leaves and a new one enters at the same edge. rbuf_vld is 0 in the next cycle.
- Reset mid-stall discards the held instruction and rbuf_vld.
- Non-load instructions never set rbuf_vld.

## Configuration
- `MS_LOAD_FWD_EN` defined:
  - fwd_valid = ms_valid && gr_we, loads included; the load data is forwarded from this stage.
  - blk_valid = 0.
- `MS_LOAD_FWD_EN` undefined:
  - fwd_valid = ms_valid && gr_we && !res_from_mem.
  - blk_valid = ms_valid && res_from_mem && gr_we, so decode stalls until the load reaches write-back.

## Test plan
- lb at addr 0x...1, rdata=0x1280_FF34, dest=5, ws_allowin=1 → final_result=0xFFFF_FFFF, rf_wen=4'hf, dest=5, ms_to_ws_valid for exactly one cycle.
- lhu at addr 0x...2, rdata=0x8001_7FFF → 0x0000_8001; lh at the same address → 0xFFFF_8001.
- lwl at a=1, rdata=0xAABB_CCDD → result 0xCCDD_0000, rf_wen=4'b1100; lwr at a=1 → result 0x00AA_BBCC, rf_wen=4'b0111.
- lw with rdata=0x1234_5678 in the first cycle, ws_allowin=0 for 3 cycles, SRAM data changed to 0xDEAD_BEEF → output holds 0x1234_5678 throughout; ms_allowin=0 during the stall; leaves when ws_allowin=1; rbuf_vld=0 afterwards.
- addu result 0x55 to dest 7 followed back-to-back by lw → addu forwarded with fwd_valid=1, blk_valid=0; lw gives blk_valid=1 when `MS_LOAD_FWD_EN` is undefined, and fwd_valid=1 with rf_data=SRAM data when defined.
- Reset asserted during a held load stall → next cycle ms_to_ws_valid=0, ms_allowin=1, rbuf_vld=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute->memory->write-back handshake, SRAM read data and forward/block bus of the memory stage
interface mem_stage_if;
  localparam int ES_TO_MS_BUS_WD = 77;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int MS_FWD_BLK_BUS_WD = 39;
  logic ws_allowin;
  logic ms_allowin;
  logic es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus
  );
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with load alignment, read-data hold across stalls and forward/block bus.
// Define MS_LOAD_FWD_EN to forward load data from this stage instead of blocking decode.
module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave ms
);
  logic        ms_valid;
  logic        rbuf_vld;
  logic [31:0] rbuf;
  logic [76:0] bus_r;
  logic        lb, lbu, lh, lhu, lwl, lwr, res_from_mem, gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result, pc, mem_data, final_result;
  logic [1:0]  a;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  rf_wen;
  logic        fwd_valid, blk_valid;
  assign {lb, lbu, lh, lhu, lwl, lwr, res_from_mem, gr_we, dest, exe_result, pc} = bus_r;
  assign a = exe_result[1:0];
  assign ms.ms_allowin = !ms_valid || ms.ws_allowin;
  assign ms.ms_to_ws_valid = ms_valid;
  always_ff @(posedge clk)
    if (reset) ms_valid <= 1'b0;
    else if (ms.ms_allowin) ms_valid <= ms.es_to_ms_valid;
  always_ff @(posedge clk)
    if (ms.es_to_ms_valid && ms.ms_allowin) bus_r <= ms.es_to_ms_bus;
  // SRAM data is only valid in a load's first cycle; a stalled load captures it once
  always_ff @(posedge clk)
    if (reset) begin
      rbuf_vld <= 1'b0;
      rbuf     <= 32'h0;
    end else if (ms_valid && ms.ws_allowin) begin
      rbuf_vld <= 1'b0;
    end else if (ms_valid && res_from_mem && !rbuf_vld) begin
      rbuf_vld <= 1'b1;
      rbuf     <= ms.data_sram_rdata;
    end
  assign mem_data = rbuf_vld ? rbuf : ms.data_sram_rdata;
  always_comb begin
    byte_v = 8'(mem_data >> {a, 3'b000});
    half_v = exe_result[1] ? mem_data[31:16] : mem_data[15:0];
    final_result = lb  ? {{24{byte_v[7]}}, byte_v} :
                   lbu ? {24'h0, byte_v} :
                   lh  ? {{16{half_v[15]}}, half_v} :
                   lhu ? {16'h0, half_v} :
                   lwl ? mem_data << {~a, 3'b000} :
                   lwr ? mem_data >> {a, 3'b000} :
                   res_from_mem ? mem_data : exe_result;
    rf_wen = !gr_we ? 4'h0 : lwl ? 4'hf << ~a : lwr ? 4'hf >> a : 4'hf;
  end
`ifdef MS_LOAD_FWD_EN
  assign fwd_valid = ms_valid && gr_we;
  assign blk_valid = 1'b0;
`else
  assign fwd_valid = ms_valid && gr_we && !res_from_mem;
  assign blk_valid = ms_valid && res_from_mem && gr_we;
`endif
  assign ms.ms_to_ws_bus = {rf_wen, dest, final_result, pc};
  assign ms.ms_fwd_blk_bus = {fwd_valid, dest, final_result, blk_valid};
endmodule
